hazard_controller: RTL



---
 rtl/hazard_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Hazard scheduler for the five-stage core: tracks destination registers in flight
// (E/M/WB scoreboard) and drives stall, flush and forward selects plus the memory watchdog.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rd_D,
    input  logic [1:0] reg_RD_D,
    input  logic       reg_WE_D,
    input  logic       is_load_D,
    input  logic       redirect_M,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       stall_WB,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_M,
    output logic       flush_WB,
    output logic [1:0] fwd_rs1_E,
    output logic [1:0] fwd_rs2_E,
    output logic       mem_fault
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
        logic [1:0] src_use;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } e_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } m_slot_t;

    // WB only ever feeds the forward mux, so the load flag is not carried into it
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } wb_slot_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    e_slot_t  e_q, e_in;
    m_slot_t  m_q, m_in;
    wb_slot_t wb_q, wb_in;
    logic [7:0] wait_cnt;
    logic       fault_q;

    logic wait_raw, mem_wait, timeout, redir, ld_use;

    function automatic logic hit(input logic valid, input logic we, input logic [4:0] rd,
                                 input logic [4:0] src, input logic used);
        return valid & we & (rd != 5'd0) & (rd == src) & used;
    endfunction

    function automatic logic [1:0] fwd_sel(input m_slot_t m, input wb_slot_t wb,
                                           input logic [4:0] src, input logic used);
        if (hit(m.valid, m.we, m.rd, src, used) && !m.load)
            return 2'b01;
        else if (hit(wb.valid, wb.we, wb.rd, src, used))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        wait_raw = dmem_req_M & ~dmem_ready;
        mem_wait = wait_raw & (wait_cnt < TIMEOUT);
        timeout  = wait_raw & (wait_cnt >= TIMEOUT);
        redir    = redirect_M & ~mem_wait;
        ld_use   = e_q.load
                 & (hit(e_q.valid, e_q.we, e_q.rd, rs1_D, reg_RD_D[0])
                  | hit(e_q.valid, e_q.we, e_q.rd, rs2_D, reg_RD_D[1]))
                 & ~mem_wait & ~redir;
    end

    // reset is active-low: every control output is forced quiet while it is held
    always_comb begin
        stall_F   = reset & (mem_wait | ld_use);
        stall_D   = reset & (mem_wait | ld_use);
        stall_E   = reset & mem_wait;
        stall_M   = reset & mem_wait;
        stall_WB  = 1'b0;
        flush_D   = reset & redir;
        flush_E   = reset & (redir | ld_use);
        flush_M   = reset & redir;
        flush_WB  = reset & mem_wait;
        fwd_rs1_E = reset ? fwd_sel(m_q, wb_q, e_q.rs1, e_q.src_use[0]) : 2'b00;
        fwd_rs2_E = reset ? fwd_sel(m_q, wb_q, e_q.rs2, e_q.src_use[1]) : 2'b00;
        mem_fault = fault_q;
    end

    always_comb begin
        e_in  = {1'b1, rd_D, reg_WE_D, is_load_D, reg_RD_D, rs1_D, rs2_D};
        m_in  = {e_q.valid, e_q.rd, e_q.we, e_q.load};
        wb_in = {m_q.valid, m_q.rd, m_q.we};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            wb_q     <= '0;
            wait_cnt <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            if (flush_E)       e_q <= '0;
            else if (!stall_E) e_q <= e_in;

            if (flush_M)       m_q <= '0;
            else if (!stall_M) m_q <= m_in;

            if (flush_WB)       wb_q <= '0;
            else if (!stall_WB) wb_q <= wb_in;

            // a timed-out access is let through once and the count restarts
            if (!wait_raw || timeout) wait_cnt <= 8'd0;
            else                      wait_cnt <= wait_cnt + 8'd1;

            if (timeout) fault_q <= 1'b1;
        end
    end

endmodule
